team_06_sample_byte_fifo: RTL and testbench
===========================================

// Module: team_06_sample_byte_fifo
// PURPOSE
//  Upstream feeder for the SPI-to-ESP serializer. Buffers 16-bit audio samples in a FIFO.
//  Splits each sample into two bytes, MSB byte first, and holds the current byte on byte_out.
//  Asserts cs while a byte is valid. Advances one byte per byte_ack pulse from the serializer side.
// PARAMETERS
//  DEPTH   16   FIFO depth in samples; power of 2, >= 2
//  ADDR_W  $clog2(DEPTH)   pointer width (derived; do not override)
// PORTS
//  clk           in   1         system clock
//  rst           in   1         reset, asynchronous, active-high
//  sample_in     in   16        audio sample, two's complement
//  sample_valid  in   1         1-cycle write strobe for sample_in
//  byte_ack      in   1         1-cycle pulse: current byte_out consumed, present next byte
//  byte_out      out  8         byte to serializer parallel input (registered)
//  cs            out  1         byte_out valid / serializer enable (registered)
//  fifo_full     out  1         level == DEPTH
//  fifo_empty    out  1         level == 0
//  level         out  ADDR_W+1  samples stored; excludes the sample being sent
//  overflow      out  1         sticky; set when a write is dropped; cleared only by rst
//  overflow_cnt  out  8         dropped-sample count; present only with TEAM_06_FIFO_STATS_EN
// BEHAVIOUR
//  Reset: ptrs=0, level=0, byte_out=8'h00, cs=0, overflow=0, overflow_cnt=0, state=IDLE, lo_hold=0.
//  Write: sample_valid && (!fifo_full || pop_this_cycle) -> mem[wr_ptr] <= sample_in, wr_ptr++.
//  Drop: sample_valid && fifo_full && !pop -> no store; overflow <= 1.
//  pop = FSM reads mem[rd_ptr] this cycle. rd_ptr++ on pop. Pointers wrap modulo DEPTH.
//  level: +1 on write-only, -1 on pop-only, unchanged when both or neither occur.
//  Flags come from registered level. A write is never popped in the same cycle.
//  FSM states:
//   IDLE: cs=0, byte_out=0.
//     If !fifo_empty: pop. byte_out <= mem[rd_ptr][15:8], lo_hold <= [7:0], cs <= 1 -> SEND_HI.
//   SEND_HI: hold byte_out and cs.
//     On byte_ack: byte_out <= lo_hold -> SEND_LO.
//   SEND_LO: on byte_ack with !fifo_empty: pop next sample, byte_out <= its [15:8] -> SEND_HI.
//     cs stays 1 (gapless stream).
//   SEND_LO: on byte_ack with fifo_empty: cs <= 0, byte_out <= 0 -> IDLE.
//  byte_ack in IDLE is ignored. byte_ack only advances one byte per pulse.
//  A multi-cycle ack advances once per cycle it is high; the serializer issues 1-cycle pulses.
//  Latency: sample_valid at cycle N into empty FIFO in IDLE.
//    level=1 at N+1; pop at N+1; byte_out/cs valid at N+2.
//  byte_out and cs change only on the clk edge after a pop or byte_ack; never glitch.
//  Reset mid-sample (any state): a partially sent sample and all stored samples are discarded.
//    Outputs return to their reset values immediately (asynchronous).
// CONFIGURATION
//  TEAM_06_FIFO_STATS_EN defined:
//    overflow_cnt port exists; +1 per dropped write, saturating at 8'hFF.
//  TEAM_06_FIFO_STATS_EN undefined:
//    port and counter are absent. overflow flag behaviour is unchanged.
// TESTING
//  1 Reset values: assert rst mid-SEND_LO with level=3.
//    -> byte_out=00, cs=0, level=0, overflow=0 at once; state IDLE after release.
//  2 Single sample: write 16'hA5C3, ack after each byte.
//    -> byte_out A5 (cs=1, N+2), then C3, then cs=0/byte_out=00 after 2nd ack.
//  3 Back-to-back: write 16'h1234 and 16'hABCD, ack 4x.
//    -> bytes 12,34,AB,CD with cs held 1 throughout; cs=0 after 4th ack.
//  4 Full/overflow: write DEPTH+2 samples with no ack.
//    -> fifo_full=1, level=DEPTH, overflow=1, overflow_cnt=2 (stats build).
//    Drain all -> first DEPTH samples are output in order.
//  5 Wrap + simultaneous: fill to full, then issue sample_valid in the same cycle
//    as the SEND_LO ack that pops. -> write accepted, level stays DEPTH,
//    overflow unchanged, data order correct across pointer wrap.
//  6 Stray ack in IDLE: pulse byte_ack with FIFO empty, then write 16'h00FF.
//    -> no state change from the stray ack; output 00 then FF.

Source files
------------

// File: rtl/team_06_sample_byte_fifo.sv
// team_06_sample_byte_fifo
//   Sample FIFO feeding the SPI-to-ESP serializer. 16-bit samples are stored
//   in a DEPTH-entry FIFO. Each one is sent as two bytes, MSB byte first. The
//   current byte is held on byte_out with cs high. Each byte_ack pulse
//   advances the stream by one byte.
//   Optional build macro: TEAM_06_FIFO_STATS_EN adds a saturating
//   dropped-sample counter on the overflow_cnt port.

module team_06_sample_byte_fifo #(
  parameter int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       sample_in,
  input  logic              sample_valid,
  input  logic              byte_ack,
  output logic [7:0]        byte_out,
  output logic              cs,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow
`ifdef TEAM_06_FIFO_STATS_EN
  ,
  output logic [7:0]        overflow_cnt
`endif
);

  localparam logic [ADDR_W:0]   FULL_LEVEL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LEVEL_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND_HI = 2'd1,
    ST_SEND_LO = 2'd2
  } state_t;

  // Storage and pointers
  logic [15:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              overflow_q, overflow_d;

  // Byte sender
  state_t            state_q, state_d;
  logic [7:0]        byte_out_q, byte_out_d;
  logic              cs_q, cs_d;
  logic [7:0]        lo_hold_q, lo_hold_d;

  // Per-cycle events
  logic              pop_s;
  logic              wr_en_s;
  logic              drop_s;
  logic [15:0]       rd_data_s;

`ifdef TEAM_06_FIFO_STATS_EN
  logic [7:0]        overflow_cnt_q, overflow_cnt_d;
`endif

  assign rd_data_s = mem_q[rd_ptr_q];

  // Sender FSM: decides when to pop and what byte to present next
  always_comb begin
    state_d    = state_q;
    byte_out_d = byte_out_q;
    cs_d       = cs_q;
    lo_hold_d  = lo_hold_q;
    pop_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_q) begin
          pop_s      = 1'b1;
          byte_out_d = rd_data_s[15:8];
          lo_hold_d  = rd_data_s[7:0];
          cs_d       = 1'b1;
          state_d    = ST_SEND_HI;
        end else begin
          byte_out_d = 8'h00;
          cs_d       = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      ST_SEND_HI: begin
        if (byte_ack) begin
          byte_out_d = lo_hold_q;
          state_d    = ST_SEND_LO;
        end else begin
          state_d    = ST_SEND_HI;
        end
      end
      ST_SEND_LO: begin
        if (byte_ack) begin
          if (!empty_q) begin
            // Gapless hand-over to the next sample: cs stays high
            pop_s      = 1'b1;
            byte_out_d = rd_data_s[15:8];
            lo_hold_d  = rd_data_s[7:0];
            cs_d       = 1'b1;
            state_d    = ST_SEND_HI;
          end else begin
            byte_out_d = 8'h00;
            cs_d       = 1'b0;
            state_d    = ST_IDLE;
          end
        end else begin
          state_d    = ST_SEND_LO;
        end
      end
      default: begin
        byte_out_d = 8'h00;
        cs_d       = 1'b0;
        lo_hold_d  = 8'h00;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // FIFO bookkeeping: accept/drop writes, advance pointers, track level and flags
  always_comb begin
    wr_en_s    = 1'b0;
    drop_s     = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;

    // A pop in the same cycle frees a slot, so a full FIFO can still accept
    if (sample_valid && (!full_q || pop_s)) begin
      wr_en_s  = 1'b1;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else if (sample_valid) begin
      drop_s     = 1'b1;
      overflow_d = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({wr_en_s, pop_s})
      2'b10:   level_d = level_q + LEVEL_ONE;
      2'b01:   level_d = level_q - LEVEL_ONE;
      default: level_d = level_q;
    endcase

    full_d  = (level_d == FULL_LEVEL);
    empty_d = (level_d == {(ADDR_W+1){1'b0}});
  end

`ifdef TEAM_06_FIFO_STATS_EN
  // Dropped-sample counter, saturating at its maximum
  always_comb begin
    if (drop_s && (overflow_cnt_q != 8'hFF)) begin
      overflow_cnt_d = overflow_cnt_q + 8'd1;
    end else begin
      overflow_cnt_d = overflow_cnt_q;
    end
  end

  // Dropped-sample counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_cnt_q <= 8'h00;
    end else begin
      overflow_cnt_q <= overflow_cnt_d;
    end
  end

  assign overflow_cnt = overflow_cnt_q;
`endif

  // Sample storage; contents are meaningless outside the pointer window, so no reset
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= sample_in;
    end
  end

  // Control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      state_q    <= ST_IDLE;
      byte_out_q <= 8'h00;
      cs_q       <= 1'b0;
      lo_hold_q  <= 8'h00;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      byte_out_q <= byte_out_d;
      cs_q       <= cs_d;
      lo_hold_q  <= lo_hold_d;
    end
  end

  assign byte_out   = byte_out_q;
  assign cs         = cs_q;
  assign fifo_full  = full_q;
  assign fifo_empty = empty_q;
  assign level      = level_q;
  assign overflow   = overflow_q;

  team_06_sample_byte_fifo_chk #(
    .DEPTH (DEPTH)
  ) u_chk (
    .clk        (clk),
    .rst        (rst),
    .byte_out   (byte_out_q),
    .cs         (cs_q),
    .fifo_full  (full_q),
    .fifo_empty (empty_q),
    .level      (level_q),
    .overflow   (overflow_q)
  );

endmodule

// Structural invariants of the FIFO outputs; has no effect on the logic.
module team_06_sample_byte_fifo_chk #(
  parameter int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input logic            clk,
  input logic            rst,
  input logic [7:0]      byte_out,
  input logic            cs,
  input logic            fifo_full,
  input logic            fifo_empty,
  input logic [ADDR_W:0] level,
  input logic            overflow
);

  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W+1)'(DEPTH);

  a_flags_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(fifo_full && fifo_empty));

  a_level_bound: assert property (@(posedge clk) disable iff (rst)
    level <= FULL_LEVEL);

  a_idle_byte_zero: assert property (@(posedge clk) disable iff (rst)
    !cs |-> (byte_out == 8'h00));

  a_overflow_sticky: assert property (@(posedge clk) disable iff (rst)
    $past(overflow) |-> overflow);

endmodule

// File: tb/tb_team_06_sample_byte_fifo.sv
// Directed bench for team_06_sample_byte_fifo: a vector table for the
// single-cycle stream behaviour plus hand-written multi-cycle sequences.
module tb_team_06_sample_byte_fifo;

  localparam int DEPTH = 16;

  logic        clk;
  logic        rst;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        byte_ack;
  logic [7:0]  byte_out;
  logic        cs;
  logic        fifo_full;
  logic        fifo_empty;
  logic [4:0]  level;
  logic        overflow;
`ifdef TEAM_06_FIFO_STATS_EN
  logic [7:0]  overflow_cnt;
`endif

  int n_pass  = 0;
  int n_total = 0;

  team_06_sample_byte_fifo #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .byte_ack     (byte_ack),
    .byte_out     (byte_out),
    .cs           (cs),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .level        (level),
    .overflow     (overflow)
`ifdef TEAM_06_FIFO_STATS_EN
    ,
    .overflow_cnt (overflow_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sv;
    logic [15:0] sin;
    logic        ack;
    logic [7:0]  e_byte;
    logic        e_cs;
    logic [4:0]  e_lvl;
    logic        e_empty;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // One clock cycle: inputs applied for exactly one edge, outputs settle 1 after it
  task automatic cyc(input logic sv, input logic [15:0] sin, input logic ack);
    @(negedge clk);
    sample_valid = sv;
    sample_in    = sin;
    byte_ack     = ack;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    sample_in    = 16'h0000;
    byte_ack     = 1'b0;
  endtask

  // Acknowledge every byte, checking each one against the expected stream
  task automatic drain(input string tag, input logic [7:0] exp_q[$]);
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("%s byte%0d", tag, i), {24'h0, byte_out}, {24'h0, exp_q[i]});
      chk($sformatf("%s cs%0d", tag, i), {31'h0, cs}, 32'h1);
      cyc(1'b0, 16'h0000, 1'b1);
    end
    chk($sformatf("%s end cs", tag), {31'h0, cs}, 32'h0);
    chk($sformatf("%s end byte", tag), {24'h0, byte_out}, 32'h0);
    chk($sformatf("%s end empty", tag), {31'h0, fifo_empty}, 32'h1);
  endtask

  initial begin
    logic [7:0]  q[$];
    logic [15:0] v;

    // Single sample A5C3
    vecs[0]  = '{1'b1, 16'hA5C3, 1'b0, 8'h00, 1'b0, 5'd1, 1'b0};
    vecs[1]  = '{1'b0, 16'h0000, 1'b0, 8'hA5, 1'b1, 5'd0, 1'b1};
    vecs[2]  = '{1'b0, 16'h0000, 1'b1, 8'hC3, 1'b1, 5'd0, 1'b1};
    vecs[3]  = '{1'b0, 16'h0000, 1'b1, 8'h00, 1'b0, 5'd0, 1'b1};
    vecs[4]  = '{1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 5'd0, 1'b1};
    // Back-to-back 1234, ABCD: second write coincides with first pop
    vecs[5]  = '{1'b1, 16'h1234, 1'b0, 8'h00, 1'b0, 5'd1, 1'b0};
    vecs[6]  = '{1'b1, 16'hABCD, 1'b0, 8'h12, 1'b1, 5'd1, 1'b0};
    vecs[7]  = '{1'b0, 16'h0000, 1'b1, 8'h34, 1'b1, 5'd1, 1'b0};
    vecs[8]  = '{1'b0, 16'h0000, 1'b1, 8'hAB, 1'b1, 5'd0, 1'b1};
    vecs[9]  = '{1'b0, 16'h0000, 1'b1, 8'hCD, 1'b1, 5'd0, 1'b1};
    vecs[10] = '{1'b0, 16'h0000, 1'b1, 8'h00, 1'b0, 5'd0, 1'b1};
    // Stray ack in IDLE, then 00FF
    vecs[11] = '{1'b0, 16'h0000, 1'b1, 8'h00, 1'b0, 5'd0, 1'b1};
    vecs[12] = '{1'b1, 16'h00FF, 1'b0, 8'h00, 1'b0, 5'd1, 1'b0};
    vecs[13] = '{1'b0, 16'h0000, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1};
    vecs[14] = '{1'b0, 16'h0000, 1'b1, 8'hFF, 1'b1, 5'd0, 1'b1};
    vecs[15] = '{1'b0, 16'h0000, 1'b1, 8'h00, 1'b0, 5'd0, 1'b1};

    rst          = 1'b1;
    sample_in    = 16'h0000;
    sample_valid = 1'b0;
    byte_ack     = 1'b0;
    #12;
    chk("rst byte_out", {24'h0, byte_out}, 32'h0);
    chk("rst cs", {31'h0, cs}, 32'h0);
    chk("rst level", {27'h0, level}, 32'h0);
    chk("rst empty", {31'h0, fifo_empty}, 32'h1);
    chk("rst full", {31'h0, fifo_full}, 32'h0);
    chk("rst overflow", {31'h0, overflow}, 32'h0);
`ifdef TEAM_06_FIFO_STATS_EN
    chk("rst overflow_cnt", {24'h0, overflow_cnt}, 32'h0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Vector table
    for (int i = 0; i < 16; i++) begin
      cyc(vecs[i].sv, vecs[i].sin, vecs[i].ack);
      chk($sformatf("vec%0d byte_out", i), {24'h0, byte_out}, {24'h0, vecs[i].e_byte});
      chk($sformatf("vec%0d cs", i), {31'h0, cs}, {31'h0, vecs[i].e_cs});
      chk($sformatf("vec%0d level", i), {27'h0, level}, {27'h0, vecs[i].e_lvl});
      chk($sformatf("vec%0d empty", i), {31'h0, fifo_empty}, {31'h0, vecs[i].e_empty});
    end

    // Wrap + simultaneous write/pop: Q goes to the sender, t0..t15 fill the FIFO
    cyc(1'b1, 16'h7E81, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      v = 16'h8000 + 16'(i) * 16'h0203;
      cyc(1'b1, v, 1'b0);
    end
    chk("wrap full", {31'h0, fifo_full}, 32'h1);
    chk("wrap level", {27'h0, level}, 32'd16);
    chk("wrap hi Q", {24'h0, byte_out}, 32'h7E);
    cyc(1'b0, 16'h0000, 1'b1);
    chk("wrap lo Q", {24'h0, byte_out}, 32'h81);
    // Ack in SEND_LO pops t0 while t16 is written
    v = 16'h8000 + 16'd16 * 16'h0203;
    cyc(1'b1, v, 1'b1);
    chk("simul level", {27'h0, level}, 32'd16);
    chk("simul full", {31'h0, fifo_full}, 32'h1);
    chk("simul overflow", {31'h0, overflow}, 32'h0);
    q.delete();
    for (int i = 0; i <= DEPTH; i++) begin
      v = 16'h8000 + 16'(i) * 16'h0203;
      q.push_back(v[15:8]);
      q.push_back(v[7:0]);
    end
    drain("wrap", q);

    // Full/overflow: sender holds P, then DEPTH+2 writes with no ack drop two
    cyc(1'b1, 16'hC0DE, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < DEPTH + 2; i++) begin
      v = 16'h1000 + 16'(i) * 16'h0101;
      cyc(1'b1, v, 1'b0);
    end
    chk("ovf full", {31'h0, fifo_full}, 32'h1);
    chk("ovf level", {27'h0, level}, 32'd16);
    chk("ovf overflow", {31'h0, overflow}, 32'h1);
    chk("ovf empty", {31'h0, fifo_empty}, 32'h0);
`ifdef TEAM_06_FIFO_STATS_EN
    chk("ovf overflow_cnt", {24'h0, overflow_cnt}, 32'd2);
`endif
    q.delete();
    q.push_back(8'hC0);
    q.push_back(8'hDE);
    for (int i = 0; i < DEPTH; i++) begin
      v = 16'h1000 + 16'(i) * 16'h0101;
      q.push_back(v[15:8]);
      q.push_back(v[7:0]);
    end
    drain("ovf", q);
    chk("ovf still set", {31'h0, overflow}, 32'h1);

    // Reset mid-SEND_LO with three samples stored
    cyc(1'b1, 16'h2101, 1'b0);
    cyc(1'b1, 16'h2202, 1'b0);
    cyc(1'b1, 16'h2303, 1'b0);
    cyc(1'b1, 16'h2404, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1);
    chk("pre-rst level", {27'h0, level}, 32'd3);
    chk("pre-rst byte", {24'h0, byte_out}, 32'h01);
    chk("pre-rst cs", {31'h0, cs}, 32'h1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst byte_out", {24'h0, byte_out}, 32'h0);
    chk("arst cs", {31'h0, cs}, 32'h0);
    chk("arst level", {27'h0, level}, 32'h0);
    chk("arst overflow", {31'h0, overflow}, 32'h0);
    chk("arst empty", {31'h0, fifo_empty}, 32'h1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 16'h0000, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0);
    chk("post-rst cs", {31'h0, cs}, 32'h0);
    chk("post-rst empty", {31'h0, fifo_empty}, 32'h1);
    // IDLE after release: a new sample appears two cycles after its write
    cyc(1'b1, 16'h5A69, 1'b0);
    chk("post-rst N+1 cs", {31'h0, cs}, 32'h0);
    chk("post-rst N+1 level", {27'h0, level}, 32'd1);
    cyc(1'b0, 16'h0000, 1'b0);
    q.delete();
    q.push_back(8'h5A);
    q.push_back(8'h69);
    drain("post-rst", q);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
